// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory instruction at a time over a single-outstanding req/ack bus.
// state | meaning:  IDLE - waiting to accept | BUSY - request on bus | DONE - one-cycle result/exception
module lsu_ctrl #(
  parameter int TIMEOUT     = 255,
  parameter int INST_ID_LEN = 6,
  parameter logic [INST_ID_LEN-1:0] ID_LB  = INST_ID_LEN'(1),
  parameter logic [INST_ID_LEN-1:0] ID_LH  = INST_ID_LEN'(2),
  parameter logic [INST_ID_LEN-1:0] ID_LW  = INST_ID_LEN'(3),
  parameter logic [INST_ID_LEN-1:0] ID_LBU = INST_ID_LEN'(4),
  parameter logic [INST_ID_LEN-1:0] ID_LHU = INST_ID_LEN'(5),
  parameter logic [INST_ID_LEN-1:0] ID_SB  = INST_ID_LEN'(6),
  parameter logic [INST_ID_LEN-1:0] ID_SH  = INST_ID_LEN'(7),
  parameter logic [INST_ID_LEN-1:0] ID_SW  = INST_ID_LEN'(8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [INST_ID_LEN-1:0] instr_id_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [4:0]             rd_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   wb_valid_o,
  output logic [31:0]            rdata_o,
  output logic [4:0]             rd_o,
  output logic                   misalign_o,
  output logic                   bus_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_be_o,
  input  logic                   mem_ack_i,
  input  logic [31:0]            mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            is_ls, is_load, sext;
  logic [1:0]      size;
  logic            misalign_in, accept, kill;
  logic [3:0]      be_in;
  logic [31:0]     wdata_in;

  logic [1:0]      off_q, size_q;
  logic            load_q, sext_q, flush_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt;
  logic            wb_q, mis_q, err_q;
  logic [31:0]     lane, load_ext;

  // size: 0 byte, 1 halfword, 2 word
  always_comb begin
    is_ls   = 1'b1;
    is_load = 1'b1;
    sext    = 1'b0;
    size    = 2'd2;
    case (instr_id_i)
      ID_LB:   begin size = 2'd0; sext = 1'b1; end
      ID_LH:   begin size = 2'd1; sext = 1'b1; end
      ID_LW:   size = 2'd2;
      ID_LBU:  size = 2'd0;
      ID_LHU:  size = 2'd1;
      ID_SB:   begin size = 2'd0; is_load = 1'b0; end
      ID_SH:   begin size = 2'd1; is_load = 1'b0; end
      ID_SW:   begin size = 2'd2; is_load = 1'b0; end
      default: begin is_ls = 1'b0; is_load = 1'b0; end
    endcase
  end

  always_comb begin
    misalign_in = ((size == 2'd1) && addr_i[0]) || ((size == 2'd2) && (addr_i[1:0] != 2'b00));
    accept      = (state == IDLE) && valid_i && !flush_i && is_ls;
    kill        = flush_q || flush_i;
    case (size)
      2'd0:    be_in = 4'b0001 << addr_i[1:0];
      2'd1:    be_in = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_in = 4'b1111;
    endcase
    case (size)
      2'd0:    wdata_in = {4{wdata_i[7:0]}};
      2'd1:    wdata_in = {2{wdata_i[15:0]}};
      default: wdata_in = wdata_i;
    endcase
  end

  always_comb begin
    lane = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = sext_q ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      2'd1:    load_ext = sext_q ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misalign_in ? DONE : BUSY;
      BUSY:    if (mem_ack_i || (cnt == TC)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q       <= 2'b00;
      size_q      <= 2'd0;
      load_q      <= 1'b0;
      sext_q      <= 1'b0;
      flush_q     <= 1'b0;
      rd_q        <= 5'd0;
      cnt         <= '0;
      wb_q        <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_o     <= 32'h0;
      rd_o        <= 5'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_be_o    <= 4'b0000;
    end else begin
      wb_q  <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          off_q   <= addr_i[1:0];
          size_q  <= size;
          load_q  <= is_load;
          sext_q  <= sext;
          rd_q    <= rd_i;
          flush_q <= 1'b0;
          cnt     <= '0;
          if (misalign_in) begin
            mis_q <= 1'b1;
          end else begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= !is_load;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_in;
            mem_wdata_o <= wdata_in;
          end
        end
        BUSY: begin
          flush_q <= kill;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (load_q && !kill) begin
              wb_q    <= 1'b1;
              rdata_o <= load_ext;
              rd_o    <= rd_q;
            end
          end else if (cnt == TC) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            err_q     <= !kill;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // a flush arriving in the DONE cycle still suppresses the result
  assign wb_valid_o = wb_q && !flush_i;
  assign misalign_o = mis_q && !flush_i;
  assign bus_err_o  = err_q && !flush_i;
  assign stall_o    = !rst_i && ((state == BUSY) || accept);

endmodule
